// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the four-way phase scheduler.
package traffic_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    ALLRED = 2'd3
  } phase_e;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick: first requester strictly after 'last',
// wrapping N,S,E,W, with 'last' itself considered at lowest priority.
module rr_arbiter4
  import traffic_pkg::*;
(
  input  logic [3:0] req,
  input  dir_e       last,
  output dir_e       grant,
  output logic       valid
);

  logic [1:0] cand [4];
  logic [3:0] hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign cand[gi] = 2'(last) + 2'(gi + 1);
    assign hit[gi]  = req[cand[gi]];
  end

  // Walk from lowest to highest priority so the nearest hit wins.
  always_comb begin
    grant = last;
    valid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) begin
        grant = dir_e'(cand[k]);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-way signal scheduler: round-robin green allocation
// bounded by min/max green, followed by yellow and all-red clearance.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] req,
  output logic [2:0] north_dir,
  output logic [2:0] south_dir,
  output logic [2:0] east_dir,
  output logic [2:0] west_dir,
  output logic [1:0] grant_dir,
  output logic       phase_active
);

  if (GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN || YELLOW_T < 1 || ALLRED_T < 1 ||
      (2 ** CNT_W) <= GREEN_MAX || (2 ** CNT_W) <= YELLOW_T ||
      (2 ** CNT_W) <= ALLRED_T) begin : g_param_check
    $fatal(1, "traffic_phase_scheduler: illegal timing parameters");
  end

  localparam logic [CNT_W:0]   GMIN_W = (CNT_W + 1)'(GREEN_MIN);
  localparam logic [CNT_W:0]   GMAX_W = (CNT_W + 1)'(GREEN_MAX);
  localparam logic [CNT_W:0]   YEL_W  = (CNT_W + 1)'(YELLOW_T);
  localparam logic [CNT_W:0]   AR_W   = (CNT_W + 1)'(ALLRED_T);
  localparam logic [CNT_W-1:0] GMAX_C = CNT_W'(GREEN_MAX);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             grant_q, grant_d;
  dir_e             last_q, last_d;
  logic             active_q, active_d;
  logic [2:0]       light_q [4];
  logic [2:0]       light_d [4];

  logic [CNT_W:0]   elapsed;
  logic [3:0]       others;
  dir_e             arb_last, arb_grant;
  logic             arb_valid;

  assign elapsed = {1'b0, cnt_q} + 1'b1;
  assign others  = req & ~(4'b0001 << grant_q);

  // Leaving ALLRED the just-served direction becomes 'last' on the same edge,
  // so the arbiter must already see it as such.
  assign arb_last = (phase_q == ALLRED) ? grant_q : last_q;

  rr_arbiter4 u_arb (
    .req   (req),
    .last  (arb_last),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (phase_q)
      IDLE: begin
        if (arb_valid) begin
          phase_d = GREEN;
          grant_d = arb_grant;
          cnt_d   = '0;
        end
      end
      GREEN: begin
        if (tick) begin
          if (others != 4'd0 &&
              ((!req[grant_q] && elapsed >= GMIN_W) || elapsed >= GMAX_W)) begin
            phase_d = YELLOW;
            cnt_d   = '0;
          end else if (elapsed >= GMAX_W) begin
            cnt_d = GMAX_C;
          end else begin
            cnt_d = elapsed[CNT_W-1:0];
          end
        end
      end
      YELLOW: begin
        if (tick) begin
          if (elapsed == YEL_W) begin
            phase_d = ALLRED;
            cnt_d   = '0;
          end else begin
            cnt_d = elapsed[CNT_W-1:0];
          end
        end
      end
      ALLRED: begin
        if (tick) begin
          if (elapsed == AR_W) begin
            last_d = grant_q;
            cnt_d  = '0;
            if (arb_valid) begin
              phase_d = GREEN;
              grant_d = arb_grant;
            end else begin
              phase_d = IDLE;
            end
          end else begin
            cnt_d = elapsed[CNT_W-1:0];
          end
        end
      end
      default: phase_d = IDLE;
    endcase
    active_d = (phase_d == GREEN) || (phase_d == YELLOW);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_light
    assign light_d[gi] = (grant_d != dir_e'(gi)) ? LIGHT_RED    :
                         (phase_d == GREEN)      ? LIGHT_GREEN  :
                         (phase_d == YELLOW)     ? LIGHT_YELLOW : LIGHT_RED;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= IDLE;
      cnt_q    <= '0;
      grant_q  <= DIR_N;
      last_q   <= DIR_W;
      active_q <= 1'b0;
      for (int i = 0; i < 4; i++) light_q[i] <= LIGHT_RED;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      active_q <= active_d;
      for (int i = 0; i < 4; i++) light_q[i] <= light_d[i];
    end
  end

  assign north_dir    = light_q[0];
  assign south_dir    = light_q[1];
  assign east_dir     = light_q[2];
  assign west_dir     = light_q[3];
  assign grant_dir    = grant_q;
  assign phase_active = active_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with hand-computed expectations.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b1;
  logic [3:0] req = 4'hF;
  logic [2:0] north_dir, south_dir, east_dir, west_dir;
  logic [1:0] grant_dir;
  logic       phase_active;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .req          (req),
    .north_dir    (north_dir),
    .south_dir    (south_dir),
    .east_dir     (east_dir),
    .west_dir     (west_dir),
    .grant_dir    (grant_dir),
    .phase_active (phase_active)
  );

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[%0t] FAIL %s: got %0h, expected %0h", $time, tag, obs, exp);
    end else begin
      $display("[%0t] ok   %s: %0h", $time, tag, obs);
    end
  endtask

  function automatic logic [11:0] lights(input int d, input logic [2:0] c);
    logic [11:0] v;
    v = {R, R, R, R};
    v[d*3 +: 3] = c;
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_state(input string tag, input int d, input logic [2:0] c,
                             input int g, input logic pa);
    expect_eq({tag, "/lights"}, {20'd0, west_dir, east_dir, south_dir, north_dir},
              {20'd0, lights(d, c)});
    expect_eq({tag, "/grant"}, {30'd0, grant_dir}, g);
    expect_eq({tag, "/active"}, {31'd0, phase_active}, {31'd0, pa});
  endtask

  task automatic restart(input logic [3:0] r);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    req = r;
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with all requests present
    reset = 1'b1; req = 4'hF; tick = 1'b1;
    cyc(2);
    check_state("reset", 0, R, 0, 1'b0);

    // Single requester: N green one cycle later, then rests
    reset = 1'b0; req = 4'b0001;
    cyc(1);  check_state("single_grant", 0, G, 0, 1'b1);
    cyc(30); check_state("single_rest_req", 0, G, 0, 1'b1);
    req = 4'b0000;
    cyc(30); check_state("single_rest_noreq", 0, G, 0, 1'b1);

    // Max-out: N green 10 ticks, yellow 3, all-red 1, then E
    restart(4'b0001);
    cyc(1); req = 4'b0101;
    cyc(8); check_state("maxout_g9", 0, G, 0, 1'b1);
    cyc(1); check_state("maxout_y0", 0, Y, 0, 1'b1);
    cyc(2); check_state("maxout_y2", 0, Y, 0, 1'b1);
    cyc(1); check_state("maxout_red", 0, R, 0, 1'b0);
    cyc(1); check_state("maxout_east", 2, G, 2, 1'b1);

    // Reset in the middle of E yellow
    cyc(10); check_state("east_yellow", 2, Y, 2, 1'b1);
    cyc(1);  reset = 1'b1;
    cyc(1);  check_state("reset_mid_yellow", 0, R, 0, 1'b0);
    reset = 1'b0; req = 4'b0000;
    cyc(1);  check_state("idle_after_reset", 0, R, 0, 1'b0);
    req = 4'b0101;
    cyc(1);  check_state("rr_ptr_reset", 0, G, 0, 1'b1);

    // Gap-out: N drops request at elapsed 2, yellow at elapsed 4
    restart(4'b0011);
    cyc(1); req = 4'b0010;
    cyc(2); check_state("gap_g3", 0, G, 0, 1'b1);
    cyc(1); check_state("gap_y0", 0, Y, 0, 1'b1);
    cyc(2); check_state("gap_y2", 0, Y, 0, 1'b1);
    cyc(1); check_state("gap_red", 0, R, 0, 1'b0);
    cyc(1); check_state("gap_south", 1, G, 1, 1'b1);

    // Round-robin with all four requesting: N,S,E,W,N
    restart(4'b1111);
    for (int k = 0; k < 4; k++) begin
      cyc(9); check_state($sformatf("rr%0d_g9", k), k, G, k, 1'b1);
      cyc(1); check_state($sformatf("rr%0d_y", k), k, Y, k, 1'b1);
      cyc(3); check_state($sformatf("rr%0d_red", k), k, R, k, 1'b0);
      cyc(1); check_state($sformatf("rr%0d_next", k), (k + 1) % 4, G, (k + 1) % 4, 1'b1);
    end

    // Tick gating: freeze mid-green, resume from frozen count
    restart(4'b0011);
    cyc(3); tick = 1'b0;
    cyc(20); check_state("frozen", 0, G, 0, 1'b1);
    tick = 1'b1;
    cyc(6); check_state("resume_g9", 0, G, 0, 1'b1);
    cyc(1); check_state("resume_y", 0, Y, 0, 1'b1);

    // IDLE->GREEN needs no tick
    reset = 1'b1; tick = 1'b0;
    cyc(1);
    reset = 1'b0; req = 4'b0100;
    cyc(1); check_state("idle_no_tick", 2, G, 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
